// File: rtl/dmglcd_scan.sv
// Scan/timing driver for the DMG LCD: walks line/pixel clocks, presents x/y to the image source, serialises value to the panel.
// Latency: every output is registered; lcd_ld captures value one clock after x/y present the pixel.
// Backpressure: none; en is only looked at in IDLE and at the last clock of a frame.
// Ports: clk/nreset/en control; x,y -> image source, value <- image source; lcd_cp/ld/st/cpl/s/fr panel pins; busy status.
module dmglcd_scan #(
    parameter int WIDTH        = 160,
    parameter int HEIGHT       = 144,
    parameter int HBLANK_CLKS  = 96,
    parameter int VBLANK_LINES = 10
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       en,
    output logic [7:0] x,
    output logic [7:0] y,
    input  logic [1:0] value,
    output logic       lcd_cp,
    output logic [1:0] lcd_ld,
    output logic       lcd_st,
    output logic       lcd_cpl,
    output logic       lcd_s,
    output logic       lcd_fr,
    output logic       busy
);
    localparam logic [15:0] PIX_CLKS   = 16'(4 * WIDTH);
    localparam logic [15:0] LINE_LAST  = 16'(4 * WIDTH + HBLANK_CLKS - 1);
    localparam logic [15:0] ACT_LINES  = 16'(HEIGHT);
    localparam logic [15:0] FRAME_LAST = 16'(HEIGHT + VBLANK_LINES - 1);

    typedef enum logic {S_IDLE, S_LINE} state_t;

    state_t      state_q, state_d;
    logic [15:0] c_q, c_d;      // clock within line
    logic [15:0] l_q, l_d;      // line within frame
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [1:0]  ld_q, ld_d;
    logic        cp_q, cp_d, st_q, st_d, cpl_q, cpl_d;
    logic        s_q, s_d, fr_q, fr_d, busy_q, busy_d;
    logic        run_d, active_d, pix_d;

    // Outputs are computed from the *next* scan position so that the
    // registered pins line up with the clock they describe.
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        l_d      = l_q;
        case (state_q)
            S_IDLE: begin
                c_d = '0;
                l_d = '0;
                if (en) state_d = S_LINE;
            end
            default: begin
                if (c_q == LINE_LAST) begin
                    c_d = '0;
                    if (l_q == FRAME_LAST) begin
                        l_d = '0;
                        if (!en) state_d = S_IDLE;
                    end else begin
                        l_d = l_q + 16'd1;
                    end
                end else begin
                    c_d = c_q + 16'd1;
                end
            end
        endcase

        run_d    = (state_d == S_LINE);
        active_d = run_d && (l_d < ACT_LINES);
        pix_d    = (c_d < PIX_CLKS);

        x_d    = (active_d && pix_d) ? c_d[9:2] : 8'd0;
        y_d    = active_d ? l_d[7:0] : 8'd0;
        cp_d   = active_d && pix_d && c_d[1];
        st_d   = active_d && (c_d >= 16'd1) && (c_d <= 16'd4);
        cpl_d  = run_d && ((c_d == PIX_CLKS + 16'd1) || (c_d == PIX_CLKS + 16'd2));
        s_d    = run_d && (l_d == 16'd0);
        busy_d = run_d;

        // Capture at 4n+1 what the source returned for pixel n during 4n;
        // hold through 4n+4 so the last falling cp edge (h=0) sees stable data.
        if (!active_d || (c_d == 16'd0) || (c_d > PIX_CLKS)) begin
            ld_d = 2'd0;
        end else if (c_d[1:0] == 2'b01) begin
            ld_d = value;
        end else begin
            ld_d = ld_q;
        end

        // Polarity restarts at 0 after IDLE and flips on every later line start,
        // including the wrap from the last line back to line 0.
        if (!run_d || (state_q == S_IDLE)) begin
            fr_d = 1'b0;
        end else if (c_d == 16'd0) begin
            fr_d = ~fr_q;
        end else begin
            fr_d = fr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            l_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ld_q    <= '0;
            cp_q    <= 1'b0;
            st_q    <= 1'b0;
            cpl_q   <= 1'b0;
            s_q     <= 1'b0;
            fr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            l_q     <= l_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ld_q    <= ld_d;
            cp_q    <= cp_d;
            st_q    <= st_d;
            cpl_q   <= cpl_d;
            s_q     <= s_d;
            fr_q    <= fr_d;
            busy_q  <= busy_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign lcd_cp  = cp_q;
    assign lcd_ld  = ld_q;
    assign lcd_st  = st_q;
    assign lcd_cpl = cpl_q;
    assign lcd_s   = s_q;
    assign lcd_fr  = fr_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_dmglcd_scan.sv
// Bench for dmglcd_scan with a small panel geometry (5x4 pixels, 5 hblank clocks, 2 blank lines).
// A frame-position reference model predicts every output each cycle; a hand-derived vector table
// and directed sequences cover start-up, frame timing, en drop, mid-frame reset and random en/reset.
`timescale 1ns/1ps
module tb_dmglcd_scan;
    localparam int W     = 5;
    localparam int H     = 4;
    localparam int HB    = 5;
    localparam int VB    = 2;
    localparam int LC    = 4 * W + HB;      // 25 clocks per line
    localparam int FRAME = LC * (H + VB);   // 150 clocks per frame

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       en = 1'b0;
    logic [7:0] x, y;
    logic [1:0] value;
    logic       lcd_cp, lcd_st, lcd_cpl, lcd_s, lcd_fr, busy;
    logic [1:0] lcd_ld;

    dmglcd_scan #(.WIDTH(W), .HEIGHT(H), .HBLANK_CLKS(HB), .VBLANK_LINES(VB)) dut (
        .clk(clk), .nreset(nreset), .en(en), .x(x), .y(y), .value(value),
        .lcd_cp(lcd_cp), .lcd_ld(lcd_ld), .lcd_st(lcd_st), .lcd_cpl(lcd_cpl),
        .lcd_s(lcd_s), .lcd_fr(lcd_fr), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Image source: fixed pattern (x + 2y + 1) mod 4, or a random lookup table.
    logic       use_rand = 1'b0;
    logic [1:0] rimg [8][8];

    always_comb begin
        if (use_rand) value = rimg[x[2:0]][y[2:0]];
        else          value = x[1:0] + {y[0], 1'b0} + 2'd1;
    end

    function automatic logic [1:0] img(int xx, int yy);
        if (use_rand) return rimg[xx[2:0]][yy[2:0]];
        return 2'((xx + 2 * yy + 1) % 4);
    endfunction

    // Reference model: position in the frame as a single clock count.
    bit m_run = 1'b0;
    int m_t = 0;
    int m_lines = 0;   // lines entered since leaving idle

    function automatic logic [23:0] expect_out();
        int L, c;
        logic a, p, ecp, est, ecpl, es, efr;
        logic [7:0] ex, ey;
        logic [1:0] eld;
        if (!m_run) return 24'd0;
        L    = m_t / LC;
        c    = m_t % LC;
        a    = (L < H);
        p    = (c < 4 * W);
        ex   = (a && p) ? 8'(c / 4) : 8'd0;
        ey   = a ? 8'(L) : 8'd0;
        ecp  = a && p && ((c % 4) >= 2);
        eld  = (a && c >= 1 && c <= 4 * W) ? img((c - 1) / 4, L) : 2'd0;
        est  = a && (c >= 1) && (c <= 4);
        ecpl = (c == 4 * W + 1) || (c == 4 * W + 2);
        es   = (L == 0);
        efr  = m_lines[0];
        return {1'b1, efr, es, ecpl, est, eld, ecp, ey, ex};
    endfunction

    function automatic logic [23:0] got_vec();
        return {busy, lcd_fr, lcd_s, lcd_cpl, lcd_st, lcd_ld, lcd_cp, y, x};
    endfunction

    task automatic chk(string nm, logic [31:0] g, logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, g, e);
        end
    endtask

    int   cyc = 0;
    logic prev_cp = 1'b0, prev_cpl = 1'b0, prev_s = 1'b0;
    logic fell_cp, rose_cpl, rose_s;

    task automatic step();
        logic [23:0] e, g;
        @(posedge clk);
        #1;
        if (!nreset) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1'b1; m_t = 0; m_lines = 0;
            end
        end else begin
            m_t++;
            if (m_t % LC == 0) m_lines++;
            if (m_t == FRAME) begin
                if (en) m_t = 0;
                else    m_run = 1'b0;
            end
        end
        cyc++;
        fell_cp  = prev_cp && !lcd_cp;
        rose_cpl = !prev_cpl && lcd_cpl;
        rose_s   = !prev_s && lcd_s;
        prev_cp  = lcd_cp;
        prev_cpl = lcd_cpl;
        prev_s   = lcd_s;
        e = expect_out();
        g = got_vec();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL scan cyc=%0d t=%0d run=%0d: got %06h expected %06h", cyc, m_t, m_run, g, e);
        end
    endtask

    typedef struct {
        int          t;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(int t, int xx, int yy, int cp, int ld, int st, int cpl, int s, int fr);
        vec_t v;
        v.t   = t;
        v.exp = {1'b1, 1'(fr), 1'(s), 1'(cpl), 1'(st), 2'(ld), 1'(cp), 8'(yy), 8'(xx)};
        tbl.push_back(v);
    endtask

    logic [23:0] snap [0:FRAME];

    initial begin
        int k, n, falls, rises, highs, line_falls, line_idx;

        //    t    x  y  cp ld st cpl s fr
        add(  0,   0, 0, 0, 0, 0, 0, 1, 0);
        add(  1,   0, 0, 0, 1, 1, 0, 1, 0);
        add(  2,   0, 0, 1, 1, 1, 0, 1, 0);
        add(  4,   1, 0, 0, 1, 1, 0, 1, 0);
        add(  5,   1, 0, 0, 2, 0, 0, 1, 0);
        add(  7,   1, 0, 1, 2, 0, 0, 1, 0);
        add( 19,   4, 0, 1, 1, 0, 0, 1, 0);
        add( 20,   0, 0, 0, 1, 0, 0, 1, 0);
        add( 21,   0, 0, 0, 0, 0, 1, 1, 0);
        add( 22,   0, 0, 0, 0, 0, 1, 1, 0);
        add( 23,   0, 0, 0, 0, 0, 0, 1, 0);
        add( 24,   0, 0, 0, 0, 0, 0, 1, 0);
        add( 25,   0, 1, 0, 0, 0, 0, 0, 1);
        add( 26,   0, 1, 0, 3, 1, 0, 0, 1);
        add( 35,   2, 1, 1, 1, 0, 0, 0, 1);
        add( 76,   0, 3, 0, 3, 1, 0, 0, 1);
        add( 94,   4, 3, 1, 3, 0, 0, 0, 1);
        add(100,   0, 0, 0, 0, 0, 0, 0, 0);
        add(102,   0, 0, 0, 0, 0, 0, 0, 0);
        add(121,   0, 0, 0, 0, 0, 1, 0, 0);
        add(146,   0, 0, 0, 0, 0, 1, 0, 1);
        add(149,   0, 0, 0, 0, 0, 0, 0, 1);
        add(150,   0, 0, 0, 0, 0, 0, 1, 0);

        // Reset held with en high: everything stays quiet.
        nreset = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reset_hold_outputs", 32'(got_vec()), 32'd0);
        end

        // First frame after release, snapshotted and compared against the table.
        nreset = 1'b1;
        for (int i = 0; i <= FRAME; i++) begin
            step();
            snap[i] = got_vec();
        end
        foreach (tbl[i]) chk($sformatf("vec_t%0d", tbl[i].t), 32'(snap[tbl[i].t]), 32'(tbl[i].exp));

        // One full frame of pulse counting, from one lcd_s rise to the next.
        k = 0; falls = 0; rises = 0; highs = 0; line_falls = 0; line_idx = 0;
        do begin
            step();
            k++;
            if (fell_cp) begin falls++; line_falls++; end
            if (lcd_cpl) highs++;
            if (rose_cpl) begin
                rises++;
                chk($sformatf("cp_falls_line%0d", line_idx), line_falls, (line_idx < H) ? W : 0);
                line_falls = 0;
                line_idx++;
            end
        end while (!rose_s && k < 4 * FRAME);
        chk("s_period", k, FRAME);
        chk("cp_falls_frame", falls, W * H);
        chk("cpl_pulses", rises, H + VB);
        chk("cpl_high_clks", highs, 2 * (H + VB));
        chk("fr_after_wrap", 32'(lcd_fr), 32'd0);

        // en dropped mid-frame (with a brief glitch): frame completes, then idle.
        for (int i = 0; i < 55; i++) step();
        en = 1'b0;
        n = 0;
        do begin
            if (n == 20) en = 1'b1;
            if (n == 21) en = 1'b0;
            step();
            n++;
        end while (busy && n < 4 * FRAME);
        chk("clks_to_idle", n, FRAME - 55);
        chk("idle_outputs", 32'(got_vec()), 32'd0);
        for (int i = 0; i < 3; i++) step();
        en = 1'b1;
        step();
        chk("restart_fr", 32'(lcd_fr), 32'd0);
        chk("restart_s", 32'(lcd_s), 32'd1);
        chk("restart_busy", 32'(busy), 32'd1);

        // Reset in the middle of line 3, pixel 2.
        for (int i = 0; i < 83; i++) step();
        chk("pre_reset_x", 32'(x), 32'd2);
        chk("pre_reset_y", 32'(y), 32'd3);
        nreset = 1'b0;
        step();
        chk("mid_reset_outputs", 32'(got_vec()), 32'd0);
        step();
        step();
        nreset = 1'b1;
        step();
        chk("restart_xy", 32'({x, y}), 32'd0);
        chk("restart2_s", 32'(lcd_s), 32'd1);
        chk("restart2_st", 32'(lcd_st), 32'd0);
        step();
        chk("restart2_st_clk1", 32'(lcd_st), 32'd1);

        // Random image, random en and occasional reset against the model.
        nreset = 1'b0;
        step();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                rimg[i][j] = 2'($urandom_range(0, 3));
        use_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            nreset = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
